riscv_vector_mem_seq: RTL and testbench

RISCV_VECTOR_MEM_SEQ -- requirements
Module: riscv_vector_mem_seq

---
 rtl/riscv_vec_pkg.sv | 28 ++
 rtl/riscv_vector_mem_seq_if.sv | 47 ++++
 rtl/riscv_vec_lane_align.sv | 27 ++
 rtl/riscv_vector_mem_seq.sv | 215 +++++++++++++++++++++
 tb/tb_riscv_vector_mem_seq.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_vec_pkg.sv
// Shared types and helpers for the vector memory sequencer.
//   state_e   : sequencer FSM states
//   SEW_*     : cmd_sew encodings (others reserved)
//   sew_bytes : element width in bytes, 0 for a reserved encoding
package riscv_vec_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam logic [2:0] SEW_8  = 3'b000;
  localparam logic [2:0] SEW_16 = 3'b001;
  localparam logic [2:0] SEW_32 = 3'b010;
  localparam logic [2:0] SEW_64 = 3'b011;

  function automatic logic [3:0] sew_bytes(input logic [2:0] sew);
    case (sew)
      SEW_8:   return 4'd1;
      SEW_16:  return 4'd2;
      SEW_32:  return 4'd4;
      SEW_64:  return 4'd8;
      default: return 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/riscv_vector_mem_seq_if.sv
// Bus bundle for the vector memory sequencer.
//   cmd_*  : command channel (valid/ready)
//   mem_*  : element-beat memory port (req/ready)
//   done_* : completion channel (valid/ready) carrying error flag and load vector
// slave  : the sequencer's view; master : the requester/memory/consumer view.
interface riscv_vector_mem_seq_if #(
  parameter int XLEN = 64,
  parameter int VLEN = 512,
  parameter int ELEN = 64
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_we;
  logic [XLEN-1:0]   cmd_base;
  logic [XLEN-1:0]   cmd_stride;
  logic              cmd_unit;
  logic [2:0]        cmd_sew;
  logic [15:0]       cmd_vl;
  logic [VLEN-1:0]   cmd_wdata;

  logic              mem_req;
  logic              mem_we;
  logic [XLEN-1:0]   mem_addr;
  logic [ELEN-1:0]   mem_wdata;
  logic [ELEN/8-1:0] mem_be;
  logic              mem_ready;
  logic [ELEN-1:0]   mem_rdata;

  logic              done_valid;
  logic              done_ready;
  logic              done_err;
  logic [VLEN-1:0]   done_data;

  modport slave (
    input  cmd_valid, cmd_we, cmd_base, cmd_stride, cmd_unit, cmd_sew, cmd_vl, cmd_wdata,
    input  mem_ready, mem_rdata, done_ready,
    output cmd_ready, mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output done_valid, done_err, done_data
  );

  modport master (
    output cmd_valid, cmd_we, cmd_base, cmd_stride, cmd_unit, cmd_sew, cmd_vl, cmd_wdata,
    output mem_ready, mem_rdata, done_ready,
    input  cmd_ready, mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  done_valid, done_err, done_data
  );
endinterface

// File: rtl/riscv_vec_lane_align.sv
// Combinational byte-lane steering between one element and the ELEN data bus.
//   wr_* : place a write element at byte offset wr_off, producing data and byte enables
//   rd_* : extract an element of rd_bytes bytes from rd_word starting at rd_off
// Element bytes above the element width are masked off on both paths.
module riscv_vec_lane_align #(
  parameter int ELEN = 64
) (
  input  logic [3:0]                 wr_bytes,
  input  logic [$clog2(ELEN/8)-1:0]  wr_off,
  input  logic [ELEN-1:0]            wr_elem,
  output logic [ELEN/8-1:0]          wr_be,
  output logic [ELEN-1:0]            wr_data,
  input  logic [3:0]                 rd_bytes,
  input  logic [$clog2(ELEN/8)-1:0]  rd_off,
  input  logic [ELEN-1:0]            rd_word,
  output logic [ELEN-1:0]            rd_elem
);
  logic [ELEN-1:0] wmask, rmask;

  // Shifting all-ones by the full width yields zero, so SEW=ELEN masks to all ones.
  assign wmask   = ~({ELEN{1'b1}} << {wr_bytes, 3'b000});
  assign rmask   = ~({ELEN{1'b1}} << {rd_bytes, 3'b000});
  assign wr_be   = (~({(ELEN/8){1'b1}} << wr_bytes)) << wr_off;
  assign wr_data = (wr_elem & wmask) << {wr_off, 3'b000};
  assign rd_elem = (rd_word >> {rd_off, 3'b000}) & rmask;

endmodule

// File: rtl/riscv_vector_mem_seq.sv
// Vector load/store sequencer: splits one unit-stride or strided vector
// command into one memory beat per element.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave view of riscv_vector_mem_seq_if (cmd / mem / done channels)
// Accept computes eff_vl = min(vl, VLEN/SEW). Beats are registered and held
// until mem_ready; a misaligned element address suppresses its beat and ends
// the command with done_err. Load elements are assembled into done_data.
module riscv_vector_mem_seq
  import riscv_vec_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int VLEN = 512,
  parameter int ELEN = 64
) (
  input logic                    clk,
  input logic                    rst_n,
  riscv_vector_mem_seq_if.slave  bus
);
  localparam int BEW  = ELEN / 8;
  localparam int OFFW = $clog2(BEW);
  localparam int IDXW = 17;

  state_e            state_q, state_d;
  logic              we_q, we_d;
  logic [XLEN-1:0]   stride_q, stride_d;
  logic [2:0]        sew_q, sew_d;
  logic [IDXW-1:0]   vl_q, vl_d, idx_q, idx_d;
  logic [VLEN-1:0]   wdata_q, wdata_d;
  logic              mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [XLEN-1:0]   mem_addr_q, mem_addr_d;
  logic [ELEN-1:0]   mem_wdata_q, mem_wdata_d;
  logic [BEW-1:0]    mem_be_q, mem_be_d;
  logic              done_err_q, done_err_d;
  logic [VLEN-1:0]   done_data_q, done_data_d;

  logic              accept, beat_done, last;
  logic [3:0]        c_bytes, cur_bytes, n_bytes;
  logic [IDXW-1:0]   c_max, c_eff, n_idx;
  logic [XLEN-1:0]   c_stride, n_addr;
  logic [VLEN-1:0]   n_vec;
  logic              n_we, n_aligned;
  logic [31:0]       n_sh, cur_sh;
  logic [ELEN-1:0]   n_elem, al_wdata, al_rd;
  logic [BEW-1:0]    al_be;

  assign accept    = bus.cmd_valid && bus.cmd_ready;
  assign beat_done = (state_q == ST_ISSUE) && mem_req_q && bus.mem_ready;
  assign last      = (idx_q == vl_q - IDXW'(1));

  // Command decode at accept time.
  always_comb begin
    c_bytes = sew_bytes(bus.cmd_sew);
    case (bus.cmd_sew)
      SEW_8:   c_max = IDXW'(VLEN / 8);
      SEW_16:  c_max = IDXW'(VLEN / 16);
      SEW_32:  c_max = IDXW'(VLEN / 32);
      SEW_64:  c_max = IDXW'(VLEN / 64);
      default: c_max = '0;
    endcase
    c_eff    = ({1'b0, bus.cmd_vl} < c_max) ? {1'b0, bus.cmd_vl} : c_max;
    c_stride = bus.cmd_unit ? XLEN'(c_bytes) : bus.cmd_stride;
  end

  // The next beat to load into the request registers: element 0 straight
  // from the command on accept, otherwise the accumulator's next element.
  always_comb begin
    cur_bytes = sew_bytes(sew_q);
    cur_sh    = 32'(idx_q) * 32'(cur_bytes) * 32'd8;
    if (state_q == ST_IDLE) begin
      n_addr  = bus.cmd_base;
      n_idx   = '0;
      n_bytes = c_bytes;
      n_vec   = bus.cmd_wdata;
      n_we    = bus.cmd_we;
    end else begin
      n_addr  = mem_addr_q + stride_q;
      n_idx   = idx_q + IDXW'(1);
      n_bytes = cur_bytes;
      n_vec   = wdata_q;
      n_we    = we_q;
    end
    n_sh      = 32'(n_idx) * 32'(n_bytes) * 32'd8;
    n_elem    = ELEN'(n_vec >> n_sh);
    n_aligned = ((n_addr[3:0] & (n_bytes - 4'd1)) == 4'd0);
  end

  riscv_vec_lane_align #(.ELEN(ELEN)) u_align (
    .wr_bytes (n_bytes),
    .wr_off   (n_addr[OFFW-1:0]),
    .wr_elem  (n_elem),
    .wr_be    (al_be),
    .wr_data  (al_wdata),
    .rd_bytes (cur_bytes),
    .rd_off   (mem_addr_q[OFFW-1:0]),
    .rd_word  (bus.mem_rdata),
    .rd_elem  (al_rd)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:
        if (accept) state_d = (c_bytes == 4'd0 || c_eff == '0) ? ST_DONE : ST_ISSUE;
      ST_ISSUE:
        // A cleared request in ISSUE means the element address was misaligned.
        if (!mem_req_q || (bus.mem_ready && last)) state_d = ST_DONE;
      ST_DONE:
        if (bus.done_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    bus.cmd_ready  = (state_q == ST_IDLE) && rst_n;
    bus.done_valid = (state_q == ST_DONE);
    bus.done_err   = done_err_q;
    bus.done_data  = done_data_q;
    bus.mem_req    = mem_req_q;
    bus.mem_we     = mem_we_q;
    bus.mem_addr   = mem_addr_q;
    bus.mem_wdata  = mem_wdata_q;
    bus.mem_be     = mem_be_q;
  end

  // Datapath next values.
  always_comb begin
    we_d        = we_q;
    stride_d    = stride_q;
    sew_d       = sew_q;
    vl_d        = vl_q;
    idx_d       = idx_q;
    wdata_d     = wdata_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    done_err_d  = done_err_q;
    done_data_d = done_data_q;

    if (state_q == ST_IDLE && accept) begin
      we_d        = bus.cmd_we;
      stride_d    = c_stride;
      sew_d       = bus.cmd_sew;
      vl_d        = c_eff;
      wdata_d     = bus.cmd_wdata;
      idx_d       = '0;
      done_data_d = '0;
      done_err_d  = (c_bytes == 4'd0);
      if (c_bytes != 4'd0 && c_eff != '0) begin
        mem_req_d   = n_aligned;
        mem_addr_d  = n_addr;
        mem_we_d    = n_we;
        mem_wdata_d = n_we ? al_wdata : '0;
        mem_be_d    = al_be;
      end
    end else if (state_q == ST_ISSUE) begin
      if (!mem_req_q) begin
        done_err_d = 1'b1;
      end else if (beat_done) begin
        if (!we_q) done_data_d = done_data_q | (VLEN'(al_rd) << cur_sh);
        idx_d = n_idx;
        if (last) begin
          mem_req_d = 1'b0;
        end else begin
          mem_req_d   = n_aligned;
          mem_addr_d  = n_addr;
          mem_wdata_d = n_we ? al_wdata : '0;
          mem_be_d    = al_be;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q        <= 1'b0;
      stride_q    <= '0;
      sew_q       <= '0;
      vl_q        <= '0;
      idx_q       <= '0;
      wdata_q     <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      done_err_q  <= 1'b0;
      done_data_q <= '0;
    end else begin
      we_q        <= we_d;
      stride_q    <= stride_d;
      sew_q       <= sew_d;
      vl_q        <= vl_d;
      idx_q       <= idx_d;
      wdata_q     <= wdata_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      done_err_q  <= done_err_d;
      done_data_q <= done_data_d;
    end
  end

endmodule

// File: tb/tb_riscv_vector_mem_seq.sv
// Bench for riscv_vector_mem_seq: table of directed commands, a mid-command
// reset sequence and random commands, all checked against a byte-level model.
module tb_riscv_vector_mem_seq;

  typedef struct {
    logic         we;
    logic [63:0]  base;
    logic [63:0]  stride;
    logic         unit;
    logic [2:0]   sew;
    logic [15:0]  vl;
    logic [511:0] wdata;
  } cmd_t;

  typedef struct {
    logic [63:0] addr;
    logic [7:0]  be;
    logic [63:0] wdata;
    logic        we;
  } beat_t;

  typedef struct {
    string name;
    cmd_t  c;
    int    stall;
    int    exp_beats;
    logic  exp_err;
    int    exp_cyc;   // -1: latency not checked
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  riscv_vector_mem_seq_if #(.XLEN(64), .VLEN(512), .ELEN(64)) bus ();

  riscv_vector_mem_seq #(.XLEN(64), .VLEN(512), .ELEN(64)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // Memory image: every byte is a function of its own address.
  function automatic logic [7:0] membyte(input logic [63:0] a);
    return a[7:0] ^ {a[11:8], a[15:12]} ^ a[23:16] ^ 8'h5C;
  endfunction

  function automatic logic [63:0] rdword(input logic [63:0] a);
    logic [63:0] w;
    logic [63:0] al;
    al = {a[63:3], 3'b000};
    for (int k = 0; k < 8; k++) w[k*8 +: 8] = membyte(al + 64'(k));
    return w;
  endfunction

  assign bus.mem_rdata = rdword(bus.mem_addr);

  function automatic logic [511:0] rnd512();
    logic [511:0] v;
    for (int k = 0; k < 16; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  int n_tot = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_tot++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  beat_t        exp_q[$];
  logic         exp_err;
  logic [511:0] exp_data;
  int           exp_cyc;

  task automatic model(input cmd_t c);
    int bytes, eff, maxe, lane;
    logic [63:0] st, a;
    beat_t b;
    exp_q.delete();
    exp_err  = 1'b0;
    exp_data = '0;
    bytes = (c.sew < 3'd4) ? (1 << c.sew) : 0;
    if (bytes == 0) begin
      exp_err = 1'b1;
      exp_cyc = 1;
      return;
    end
    maxe = 512 / (8 * bytes);
    eff  = (int'(c.vl) < maxe) ? int'(c.vl) : maxe;
    st   = c.unit ? 64'(bytes) : c.stride;
    exp_cyc = eff + 1;
    for (int i = 0; i < eff; i++) begin
      a = c.base + 64'(i) * st;
      if (a % 64'(bytes) != 0) begin
        exp_err = 1'b1;
        exp_cyc = i + 2;
        break;
      end
      b.addr = a; b.we = c.we; b.be = '0; b.wdata = '0;
      for (int j = 0; j < bytes; j++) begin
        lane = int'(a % 64'd8) + j;
        b.be[lane] = 1'b1;
        if (c.we) b.wdata[lane*8 +: 8] = c.wdata[(i*bytes + j)*8 +: 8];
        else      exp_data[(i*bytes + j)*8 +: 8] = membyte(a + 64'(j));
      end
      exp_q.push_back(b);
    end
  endtask

  // ---------------- driver / monitor ----------------
  beat_t        got_q[$];
  logic         got_err;
  logic [511:0] got_data;
  int           got_cyc;

  task automatic run_cmd(input string nm, input cmd_t c, input int stall);
    int w, scnt;
    bit done;
    beat_t ref_b, cur;
    got_q.delete();
    got_err = 1'b0; got_data = '0; got_cyc = -1;
    done = 0; scnt = 0;
    ref_b = '{default: '0};
    @(negedge clk);
    bus.cmd_we = c.we; bus.cmd_base = c.base; bus.cmd_stride = c.stride;
    bus.cmd_unit = c.unit; bus.cmd_sew = c.sew; bus.cmd_vl = c.vl;
    bus.cmd_wdata = c.wdata; bus.cmd_valid = 1'b1; bus.done_ready = 1'b0;
    w = 0;
    while (!bus.cmd_ready && w < 20) begin @(negedge clk); w++; end
    if (!bus.cmd_ready) begin
      chk({nm, " accept_timeout"}, 512'(0), 512'(1));
      bus.cmd_valid = 1'b0;
      return;
    end
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    for (int cyc = 1; cyc < 3000; cyc++) begin
      if (bus.done_valid) begin
        got_cyc = cyc; got_err = bus.done_err; got_data = bus.done_data;
        bus.done_ready = 1'b1;
        @(negedge clk);
        bus.done_ready = 1'b0;
        done = 1;
        break;
      end
      if (bus.mem_req) begin
        cur.addr = bus.mem_addr; cur.be = bus.mem_be; cur.wdata = bus.mem_wdata; cur.we = bus.mem_we;
        if (scnt > 0) begin
          chk($sformatf("%s stable_addr b%0d", nm, got_q.size()), 512'(cur.addr), 512'(ref_b.addr));
          chk($sformatf("%s stable_data b%0d", nm, got_q.size()), 512'({cur.be, cur.wdata, cur.we}),
              512'({ref_b.be, ref_b.wdata, ref_b.we}));
        end
        if (scnt < stall) begin
          if (scnt == 0) ref_b = cur;
          bus.mem_ready = 1'b0;
          scnt++;
        end else begin
          got_q.push_back(cur);
          bus.mem_ready = 1'b1;
          scnt = 0;
        end
      end else begin
        bus.mem_ready = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
    end
    if (!done) chk({nm, " done_timeout"}, 512'(0), 512'(1));
  endtask

  task automatic check_run(input string nm, input int stall, input int e_beats,
                           input logic e_err, input int e_cyc);
    int n;
    chk({nm, " beats"}, 512'(got_q.size()), 512'(e_beats));
    chk({nm, " model_beats"}, 512'(got_q.size()), 512'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s addr%0d", nm, i), 512'(got_q[i].addr), 512'(exp_q[i].addr));
      chk($sformatf("%s be%0d", nm, i), 512'(got_q[i].be), 512'(exp_q[i].be));
      chk($sformatf("%s we%0d", nm, i), 512'(got_q[i].we), 512'(exp_q[i].we));
      if (exp_q[i].we) chk($sformatf("%s wdata%0d", nm, i), 512'(got_q[i].wdata), 512'(exp_q[i].wdata));
    end
    chk({nm, " err"}, 512'(got_err), 512'(e_err));
    chk({nm, " data"}, got_data, exp_data);
    if (stall == 0) chk({nm, " done_cycle"}, 512'(got_cyc), 512'(e_cyc));
  endtask

  // ---------------- test ----------------
  vec_t         vt[8];
  logic [511:0] wd_st, save_data;
  logic [63:0]  a41[4];
  logic [7:0]   b41[4];
  logic [63:0]  a42[3];
  logic [7:0]   b42[3];
  cmd_t         ld41, st42, rc;
  int           rstall, rb;

  initial begin
    wd_st = rnd512();
    ld41 = '{we: 1'b0, base: 64'h1000, stride: 64'h0, unit: 1'b1, sew: 3'b010, vl: 16'd4, wdata: rnd512()};
    st42 = '{we: 1'b1, base: 64'h2010, stride: 64'hFFFF_FFFF_FFFF_FFFA, unit: 1'b0, sew: 3'b001, vl: 16'd3, wdata: wd_st};
    vt[0] = '{"ld_unit32",  ld41, 0, 4, 1'b0, 5};
    vt[1] = '{"st_stride16", st42, 0, 3, 1'b0, 4};
    vt[2] = '{"ld_stall",   ld41, 3, 4, 1'b0, -1};
    vt[3] = '{"st_stall",   st42, 3, 3, 1'b0, -1};
    vt[4] = '{"misalign64", '{1'b0, 64'h1004, 64'h0, 1'b1, 3'b011, 16'd4, '0}, 0, 0, 1'b1, 2};
    vt[5] = '{"rsv_sew",    '{1'b0, 64'h1000, 64'h0, 1'b1, 3'b100, 16'd4, '0}, 0, 0, 1'b1, 1};
    vt[6] = '{"vl_zero",    '{1'b0, 64'h1000, 64'h0, 1'b1, 3'b010, 16'd0, '0}, 0, 0, 1'b0, 1};
    vt[7] = '{"clamp8",     '{1'b0, 64'h4000, 64'h0, 1'b1, 3'b000, 16'd100, '0}, 0, 64, 1'b0, 65};
    a41 = '{64'h1000, 64'h1004, 64'h1008, 64'h100C};
    b41 = '{8'h0F, 8'hF0, 8'h0F, 8'hF0};
    a42 = '{64'h2010, 64'h200A, 64'h2004};
    b42 = '{8'h03, 8'h0C, 8'h30};
    save_data = '0;

    rst_n = 1'b0;
    bus.cmd_valid = 0; bus.cmd_we = 0; bus.cmd_base = 0; bus.cmd_stride = 0;
    bus.cmd_unit = 0; bus.cmd_sew = 0; bus.cmd_vl = 0; bus.cmd_wdata = '0;
    bus.mem_ready = 0; bus.done_ready = 0;
    #1;
    chk("rst cmd_ready", 512'(bus.cmd_ready), 512'(0));
    chk("rst mem_req", 512'({bus.mem_req, bus.mem_we, bus.mem_be}), 512'(0));
    chk("rst mem_addr", 512'({bus.mem_addr, bus.mem_wdata}), 512'(0));
    chk("rst done", 512'({bus.done_valid, bus.done_err}), 512'(0));
    chk("rst done_data", bus.done_data, 512'(0));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rst release cmd_ready", 512'(bus.cmd_ready), 512'(1));

    for (int v = 0; v < 8; v++) begin
      model(vt[v].c);
      run_cmd(vt[v].name, vt[v].c, vt[v].stall);
      check_run(vt[v].name, vt[v].stall, vt[v].exp_beats, vt[v].exp_err, vt[v].exp_cyc);
      if (v == 0) begin
        save_data = got_data;
        for (int i = 0; i < 4 && i < got_q.size(); i++) begin
          chk($sformatf("unit32 const_addr%0d", i), 512'(got_q[i].addr), 512'(a41[i]));
          chk($sformatf("unit32 const_be%0d", i), 512'(got_q[i].be), 512'(b41[i]));
        end
      end
      if (v == 1) begin
        for (int i = 0; i < 3 && i < got_q.size(); i++) begin
          chk($sformatf("stride16 const_addr%0d", i), 512'(got_q[i].addr), 512'(a42[i]));
          chk($sformatf("stride16 const_be%0d", i), 512'(got_q[i].be), 512'(b42[i]));
        end
        if (got_q.size() == 3) begin
          chk("stride16 lane1", 512'(got_q[1].wdata), 512'({32'h0, wd_st[31:16], 16'h0}));
          chk("stride16 lane2", 512'(got_q[2].wdata), 512'({16'h0, wd_st[47:32], 32'h0}));
        end
      end
      if (v == 2) chk("stall vs nostall data", got_data, save_data);
    end

    // Reset pulsed while beat 2 of a load is outstanding.
    rc = '{we: 1'b0, base: 64'h3000, stride: 64'h0, unit: 1'b1, sew: 3'b010, vl: 16'd8, wdata: '0};
    @(negedge clk);
    bus.cmd_we = rc.we; bus.cmd_base = rc.base; bus.cmd_stride = rc.stride; bus.cmd_unit = rc.unit;
    bus.cmd_sew = rc.sew; bus.cmd_vl = rc.vl; bus.cmd_wdata = rc.wdata;
    bus.cmd_valid = 1'b1; bus.mem_ready = 1'b1;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("midrst beat2_req", 512'(bus.mem_req), 512'(1));
    chk("midrst beat2_addr", 512'(bus.mem_addr), 512'(64'h3008));
    rst_n = 1'b0;
    #1;
    chk("midrst mem_req", 512'(bus.mem_req), 512'(0));
    chk("midrst idle", 512'({bus.cmd_ready, bus.done_valid, bus.mem_addr}), 512'(0));
    @(negedge clk);
    rst_n = 1'b1;
    bus.mem_ready = 1'b0;
    model(rc);
    run_cmd("after_rst", rc, 0);
    check_run("after_rst", 0, 8, 1'b0, 9);

    // Random commands against the model.
    for (int r = 0; r < 40; r++) begin
      rc.we   = 1'($urandom_range(0, 1));
      rc.sew  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
      rb      = (rc.sew < 3'd4) ? (1 << rc.sew) : 1;
      rc.base = {$urandom, $urandom};
      if ($urandom_range(0, 9) != 0) rc.base = rc.base & ~64'(rb - 1);
      rc.unit   = 1'($urandom_range(0, 1));
      rc.stride = 64'((int'($urandom_range(0, 8)) - 4) * rb);
      if ($urandom_range(0, 7) == 0) rc.stride = rc.stride + 64'd1;
      rc.vl    = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(60, 200)) : 16'($urandom_range(0, 12));
      rc.wdata = rnd512();
      rstall   = $urandom_range(0, 2);
      model(rc);
      run_cmd($sformatf("rnd%0d", r), rc, rstall);
      check_run($sformatf("rnd%0d", r), rstall, exp_q.size(), exp_err, exp_cyc);
    end

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
